// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding read/write, an internal word array, backpressured responses.
// Optional alignment check is compiled in with `define MEM_RESP_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              count;
  logic                    we_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    enter_resp;
  logic                    req_err;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state == WAIT) && (count == 4'd0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign req_err = (|req_addr[31:ADDR_WIDTH+2]) || (|req_addr[1:0]);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^req_addr[1:0];
  assign req_err = |req_addr[31:ADDR_WIDTH+2];
`endif

  // Array has no reset; a write lands only on the edge that enters RESP, so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (enter_resp && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // The counter holds the remaining wait cycles; RESP is entered on the edge after it reaches zero,
  // which puts resp_valid LATENCY edges after the accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            err_q     <= req_err;
            idx_q     <= req_addr[ADDR_WIDTH+1:2];
            wdata_q   <= req_wdata;
            count     <= 4'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (we_q || err_q) ? 32'd0 : mem[idx_q];
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic against a word-array model.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        f_req_valid, f_req_ready, f_req_we, f_resp_valid, f_resp_ready, f_resp_err;
  logic [31:0] f_req_addr, f_req_wdata, f_resp_rdata;

  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  logic [31:0] model_mem [256];
  logic [31:0] fast_mem  [256];

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_fast (
    .clk(clk), .reset(reset),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .resp_valid(f_resp_valid), .resp_ready(f_resp_ready),
    .resp_rdata(f_resp_rdata), .resp_err(f_resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory is 256 words = 1024 bytes; anything at or above that byte address is rejected.
  function automatic logic model_err(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    return (a >= 32'd1024) || (a % 4 != 0);
`else
    return a >= 32'd1024;
`endif
  endfunction

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          n;
    exp_err   = model_err(addr);
    exp_rdata = (we || exp_err) ? 32'd0 : model_mem[(addr / 4) % 256];
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check("latency_valid_low", 32'(resp_valid), 32'd0);
      check("wait_ready_low", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_ready_low", 32'(req_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("done_valid", 32'(resp_valid), 32'd0);
    check("done_rdata", resp_rdata, 32'd0);
    check("done_err", 32'(resp_err), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
    if (we && !exp_err) model_mem[(addr / 4) % 256] = wdata;
  endtask

  initial begin
    logic [31:0] a, d, exp;
    logic        we;
    int          n;
    time         t_prev, t_acc;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    f_req_valid = 1'b0; f_req_we = 1'b0; f_req_addr = 32'd0; f_req_wdata = 32'd0; f_resp_ready = 1'b0;
    t_prev = 0;

    #3 reset = 1'b0;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Give every word in the traffic pool a known value.
    for (int w = 0; w < 16; w++) do_txn(1'b1, 32'(w * 4), $urandom, 0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h10, 32'd0, 0);
    check("readback_model", model_mem[4], 32'hDEADBEEF);

    do_txn(1'b0, 32'h10, 32'd0, 5);

    do_txn(1'b1, 32'h400, 32'h12345678, 0);
    do_txn(1'b0, 32'h0, 32'd0, 0);

    do_txn(1'b1, 32'h10, 32'hCAFEF00D, 0);
    do_txn(1'b0, 32'h13, 32'd0, 0);

    // Reset while a write sits in WAIT; the old word must survive.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("rst_mid_req_ready_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_txn(1'b0, 32'h20, 32'd0, 0);

    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a + (32'd1 << $urandom_range(10, 31));
      do_txn(we, a, $urandom, int'($urandom_range(0, 2)));
    end

    // LATENCY=1 instance with req_valid and resp_ready held high: one accept every 3 cycles.
    f_resp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      we = (i < 4);
      a  = 32'h40 + 32'((i % 4) * 4);
      d  = $urandom;
      f_req_valid = 1'b1; f_req_we = we; f_req_addr = a; f_req_wdata = d;
      n = 0;
      while (f_req_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("fast_accept_timeout", 32'(n < 20), 32'd1);
      @(posedge clk);
      t_acc = $time;
      if (i > 0) check("fast_interval", 32'(t_acc - t_prev), 32'd30);
      t_prev = t_acc;
      exp = we ? 32'd0 : fast_mem[a / 4];
      if (we) fast_mem[a / 4] = d;
      @(negedge clk);
      check("fast_wait_valid", 32'(f_resp_valid), 32'd0);
      @(negedge clk);
      check("fast_resp_valid", 32'(f_resp_valid), 32'd1);
      check("fast_resp_rdata", f_resp_rdata, exp);
      check("fast_resp_err", 32'(f_resp_err), 32'd0);
      @(negedge clk);
      check("fast_valid_one_cycle", 32'(f_resp_valid), 32'd0);
      check("fast_req_ready", 32'(f_req_ready), 32'd1);
    end
    f_req_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
